// File: rtl/pipeline_stall_unit_pkg.sv
// pipeline_stall_unit_pkg: shared core pipeline state encoding and stage indices
package pipeline_stall_unit_pkg;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_WAIT   = 2'd1,
        EXC_FLUSH = 2'd2,
        HALT      = 2'd3
    } state_e;
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int CNT_W   = 8;
endpackage

// File: rtl/pipeline_stall_unit_md_cycle_counter.sv
// md_cycle_counter: loadable non-wrapping down counter for multi-cycle EXE operations
module md_cycle_counter
    import pipeline_stall_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr_i ? '0 : load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/pipeline_stall_unit.sv
// pipeline_stall_unit: pipeline register enables/flushes for hazards, multi-cycle EXE and traps
module pipeline_stall_unit
    import pipeline_stall_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic load_use_hazard,
    input  logic branch_taken,
    input  logic md_start,
    input  logic md_is_div,
    input  logic exception_req,
    output logic pc_ena,
    output logic if_id_ena,
    output logic id_exe_ena,
    output logic exe_mem_ena,
    output logic mem_wb_ena,
    output logic if_id_flush,
    output logic id_exe_flush,
    output logic exe_mem_flush,
    output logic md_busy,
    output logic stall_active
);
    state_e           state_q, state_d;
    logic [2:0]       fill_q, fill_d;
    logic             run, in_run, in_md, in_exc, start, br, luh, front, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign run    = ena & ~reset;
    assign in_run = state_q == RUN;
    assign in_md  = state_q == MD_WAIT;
    assign in_exc = state_q == EXC_FLUSH;
    // RUN-state priority: exception > md_start > branch > load-use
    assign start  = in_run & md_start & ~exception_req;
    assign br     = in_run & branch_taken & ~md_start & ~exception_req;
    assign luh    = in_run & load_use_hazard & ~branch_taken & ~md_start & ~exception_req;
    assign front  = run & (in_exc | (in_run & ~start & ~luh));

    assign cnt_load_val = md_is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);

    md_cycle_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (exception_req),
        .load_i     (start & ena),
        .load_val_i (cnt_load_val),
        .dec_i      (in_md & ena),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = exception_req ? EXC_FLUSH :
                  in_run        ? (!ena ? HALT : md_start ? MD_WAIT : RUN) :
                  in_md         ? ((ena && cnt_zero) ? RUN : MD_WAIT) :
                  in_exc        ? RUN :
                  ena           ? RUN : HALT;
        fill_d  = ena ? {fill_q[1:0], 1'b1} : fill_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    assign pc_ena        = front;
    assign if_id_ena     = front;
    assign id_exe_ena    = run & fill_q[STG_ID-1] & (in_exc | (in_run & ~start));
    assign exe_mem_ena   = run & fill_q[STG_EXE-1] & (in_exc | (in_run & ~start) | (in_md & cnt_zero));
    assign mem_wb_ena    = run & fill_q[STG_MEM-1] & (state_q != HALT);
    assign if_id_flush   = run & (in_exc | br);
    assign id_exe_flush  = run & (in_exc | br | luh);
    assign exe_mem_flush = run & in_exc;
    assign md_busy       = ~reset & in_md;
    assign stall_active  = run & ~(pc_ena & if_id_ena);
endmodule

// File: doc/pipeline_stall_unit.md
PIPELINE_STALL_UNIT -- requirements
Module: pipeline_stall_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4: total EXE occupancy of a multiply, in cycles (2..255).
REQ-002 Parameter DIV_CYCLES, default 33: total EXE occupancy of a divide, in cycles (2..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ena  in  1  global run enable; low = pipeline frozen.
REQ-006 load_use_hazard  in  1  ID instruction needs a load result still in EXE.
REQ-007 branch_taken  in  1  EXE resolved a taken branch/jump.
REQ-008 md_start  in  1  EXE holds a multiply/divide starting this cycle.
REQ-009 md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-010 exception_req  in  1  trap/interrupt redirect request.
REQ-011 pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena  out  1 each  pipeline register load enables.
REQ-012 if_id_flush, id_exe_flush, exe_mem_flush  out  1 each  insert bubble into that register on this edge.
REQ-013 md_busy  out  1  multi-cycle operation occupying EXE.
REQ-014 stall_active  out  1  any of pc_ena/if_id_ena is 0 while ena=1.

Function
REQ-015 States: RUN, MD_WAIT, EXC_FLUSH, HALT; encoding 2 bits.
REQ-016 Fill vector fill[2:0] SHALL shift {fill[1:0],1'b1} each cycle ena=1 and hold otherwise; stage gating: id_exe_ena needs fill[0], exe_mem_ena needs fill[1], mem_wb_ena needs fill[2]; pc_ena/if_id_ena need ena only.
REQ-017 RUN, no hazard inputs, ena=1: all five enables 1 (subject to fill), all flushes 0.
REQ-018 RUN, load_use_hazard=1: pc_ena=0, if_id_ena=0, id_exe_flush=1, others as REQ-017.
REQ-019 RUN, branch_taken=1: if_id_flush=1, id_exe_flush=1, pc_ena=1, if_id_ena=1; branch overrides load_use_hazard in the same cycle.
REQ-020 RUN, md_start=1: state goes MD_WAIT next cycle; counter loads (md_is_div ? DIV_CYCLES : MUL_CYCLES)-2; start cycle itself behaves as REQ-017 except exe_mem_ena=0 and pc_ena/if_id_ena/id_exe_ena=0.
REQ-021 MD_WAIT: pc_ena, if_id_ena, id_exe_ena=0; exe_mem_ena=0; mem_wb_ena per fill; md_busy=1; counter decrements each ena=1 cycle; at counter=0 exe_mem_ena=1 and state returns to RUN next cycle (total EXE occupancy = N cycles).
REQ-022 MD_WAIT ignores load_use_hazard, branch_taken, md_start.
REQ-023 exception_req=1 in any state: highest priority; next state EXC_FLUSH, counter cleared, md_busy drops next cycle.
REQ-024 EXC_FLUSH (one cycle): pc_ena=1, all three flushes 1, all register enables 1; then RUN.
REQ-025 RUN with ena=0: next state HALT; HALT: all enables 0, flushes 0; returns to RUN on the first cycle ena=1.
REQ-026 MD_WAIT with ena=0: all enables 0, counter and state frozen.
REQ-027 Priority in RUN: exception_req > md_start > branch_taken > load_use_hazard.
REQ-028 Counter width 8 bits; no wrap: decrement only when nonzero.

Reset
REQ-029 While reset=1: state RUN, fill=3'b000, counter=0; all enables 0, all flushes 0, md_busy=0, stall_active=0.
REQ-030 reset asserted mid-MD_WAIT or mid-EXC_FLUSH aborts immediately to REQ-029 values on the next edge.

Structure
REQ-031 State encoding and stage indices (IF/ID/EXE/MEM/WB) SHALL live in the shared core package.
REQ-032 Multi-cycle countdown SHALL be one sub-module, md_cycle_counter (load, dec, zero flag).

Verification
REQ-033 Reset released, ena=1 held: id_exe_ena rises cycle 1, exe_mem_ena cycle 2, mem_wb_ena cycle 3.
REQ-034 Filled pipe, load_use_hazard 1 cycle: pc_ena=0, if_id_ena=0, id_exe_flush=1 that cycle only.
REQ-035 load_use_hazard and branch_taken together: if_id_flush=1, id_exe_flush=1, pc_ena=1.
REQ-036 md_start with md_is_div=1: md_busy high 32 cycles, exe_mem_ena low 32 cycles then 1; with md_is_div=0: 3 cycles.
REQ-037 exception_req on cycle 5 of a divide: next cycle EXC_FLUSH, all flushes 1, md_busy=0, then RUN.
REQ-038 ena low 3 cycles during MD_WAIT: all enables 0, completion delayed exactly 3 cycles.
